// File: rtl/mon_capture_buf_if.sv
// mon_capture_buf_if: monitor stream, host control and read-port bundle for mon_capture_buf
interface mon_capture_buf_if #(parameter int aw = 13, parameter int dw = 20);
  logic [dw-1:0] mon_result;
  logic          mon_strobe;
  logic          mon_boundary;
  logic          start;
  logic          trig_sel;
  logic          ext_trig;
  logic [aw-1:0] rd_addr;
  logic [dw-1:0] rd_data;
  logic          running;
  logic          ready;
  logic [aw:0]   wr_count;
  logic [31:0]   ts_capture;
  modport master (
    output mon_result, mon_strobe, mon_boundary, start, trig_sel, ext_trig, rd_addr,
    input  rd_data, running, ready, wr_count, ts_capture
  );
  modport slave (
    input  mon_result, mon_strobe, mon_boundary, start, trig_sel, ext_trig, rd_addr,
    output rd_data, running, ready, wr_count, ts_capture
  );
endinterface

// File: rtl/mon_capture_buf.sv
// mon_capture_buf: frame-aligned 2^aw-word capture buffer; MON_CAPTURE_TIMESTAMP_EN adds a cycle timestamp of the first write
module mon_capture_buf #(
  parameter int aw = 13,
  parameter int dw = 20
) (
  input logic clk,
  input logic reset,
  mon_capture_buf_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARMED, SYNC, FILL, DONE} state_t;
  state_t        state_q;
  logic          running_q;
  logic          ready_q;
  logic [aw:0]   wr_count_q;
  logic [dw-1:0] rd_data_q;
  logic [dw-1:0] mem_q [2**aw];
  logic          wr_en;
  assign wr_en = (state_q == FILL) && bus.mon_strobe;
  // running/ready are set alongside every state change so they never lag the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      ready_q    <= 1'b0;
      wr_count_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_q    <= bus.trig_sel ? ARMED : SYNC;
          running_q  <= 1'b1;
          ready_q    <= 1'b0;
          wr_count_q <= '0;
        end
        ARMED: if (bus.ext_trig) state_q <= SYNC;
        SYNC: if (bus.mon_boundary) state_q <= FILL;
        FILL: if (bus.mon_strobe) begin
          wr_count_q <= wr_count_q + 1'b1;
          if (&wr_count_q[aw-1:0]) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_count_q[aw-1:0]] <= bus.mon_result;
    rd_data_q <= mem_q[bus.rd_addr];
  end
  assign bus.rd_data  = rd_data_q;
  assign bus.running  = running_q;
  assign bus.ready    = ready_q;
  assign bus.wr_count = wr_count_q;
`ifdef MON_CAPTURE_TIMESTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] ts_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (wr_en && wr_count_q == '0) ts_q <= cyc_q;
    end
  end
  assign bus.ts_capture = ts_q;
`else
  assign bus.ts_capture = '0;
`endif
endmodule

// File: tb/tb_mon_capture_buf.sv
// tb_mon_capture_buf: directed scoreboard bench for mon_capture_buf (aw=4, dw=20)
module tb_mon_capture_buf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic rd_en = 1'b0;
  logic rd_vld = 1'b0;
  logic [19:0] exp_q [$];
  mon_capture_buf_if #(.aw(4), .dw(20)) m ();
  mon_capture_buf #(.aw(4), .dw(20)) dut (.clk(clk), .reset(reset), .bus(m));
  always #5 clk = ~clk;
  always @(posedge clk) rd_vld <= rd_en;
  always @(negedge clk) begin
    if (rd_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %0d, no expected value queued", m.rd_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if (m.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0d, expected %0d", m.rd_data, e);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask
  task automatic drive(input logic s, input logic b, input logic [19:0] d);
    m.mon_strobe = s;
    m.mon_boundary = b;
    m.mon_result = d;
    tick();
    m.mon_strobe = 1'b0;
    m.mon_boundary = 1'b0;
  endtask
  task automatic arm(input logic ts);
    m.trig_sel = ts;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
  endtask
  task automatic fill(input int base);
    for (int k = 1; k <= 16; k++) drive(1'b1, 1'b0, 20'(base + k));
  endtask
  task automatic read_all(input int base);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(20'(base + k + 1));
      m.rd_addr = 4'(k);
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    tick();
    tick();
  endtask
  task automatic chk_done(input string n);
    chk({n, "_ready"}, 32'(m.ready), 32'd1);
    chk({n, "_running"}, 32'(m.running), 32'd0);
    chk({n, "_wr_count"}, 32'(m.wr_count), 32'd16);
  endtask
  initial begin
    m.mon_result = '0;
    m.mon_strobe = 1'b0;
    m.mon_boundary = 1'b0;
    m.start = 1'b0;
    m.trig_sel = 1'b0;
    m.ext_trig = 1'b0;
    m.rd_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_running", 32'(m.running), 32'd0);
    chk("rst_ready", 32'(m.ready), 32'd0);
    chk("rst_wr_count", 32'(m.wr_count), 32'd0);
    chk("rst_ts", m.ts_capture, 32'd0);
    // 1: basic capture
    arm(1'b0);
    chk("t1_running", 32'(m.running), 32'd1);
    drive(1'b0, 1'b1, 20'd0);
    fill(0);
    chk_done("t1");
    read_all(0);
    // 2: strobe coincident with boundary is dropped
    arm(1'b0);
    chk("t2_ready_drop", 32'(m.ready), 32'd0);
    drive(1'b1, 1'b1, 20'd99);
    fill(200);
    chk_done("t2");
    read_all(200);
    // 3: external trigger gating
    arm(1'b1);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 20'd77);
    chk("t3_running", 32'(m.running), 32'd1);
    chk("t3_wr_count", 32'(m.wr_count), 32'd0);
    m.ext_trig = 1'b1;
    tick();
    m.ext_trig = 1'b0;
    drive(1'b1, 1'b1, 20'd88);
    fill(300);
    chk_done("t3");
    read_all(300);
    // 4: reset mid-fill
    arm(1'b0);
    drive(1'b0, 1'b1, 20'd0);
    for (int k = 1; k <= 7; k++) drive(1'b1, 1'b0, 20'(400 + k));
    chk("t4_wr_count7", 32'(m.wr_count), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_running", 32'(m.running), 32'd0);
    chk("t4_ready", 32'(m.ready), 32'd0);
    chk("t4_wr_count", 32'(m.wr_count), 32'd0);
    arm(1'b0);
    drive(1'b0, 1'b1, 20'd0);
    fill(500);
    chk_done("t4");
    read_all(500);
    // 5: start ignored during fill, strobes ignored after done
    arm(1'b0);
    drive(1'b0, 1'b1, 20'd0);
    for (int k = 1; k <= 16; k++) begin
      m.start = (k % 4 == 0);
      drive(1'b1, 1'b0, 20'(600 + k));
    end
    m.start = 1'b0;
    chk_done("t5");
    for (int k = 0; k < 5; k++) drive(1'b1, k[0], 20'd999);
    chk_done("t5_post");
    read_all(600);
    // 6: timestamp of first write, counted from reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    arm(1'b0);
    drive(1'b0, 1'b1, 20'd0);
    repeat (48) tick();
    drive(1'b1, 1'b0, 20'd700);
`ifdef MON_CAPTURE_TIMESTAMP_EN
    chk("t6_ts", m.ts_capture, 32'd50);
`else
    chk("t6_ts", m.ts_capture, 32'd0);
`endif
    chk("t6_wr_count", 32'(m.wr_count), 32'd1);
    repeat (3) drive(1'b1, 1'b0, 20'd701);
`ifdef MON_CAPTURE_TIMESTAMP_EN
    chk("t6_ts_hold", m.ts_capture, 32'd50);
`else
    chk("t6_ts_hold", m.ts_capture, 32'd0);
`endif
    tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
